// File: rtl/hazard_tag_pipeline_pkg.sv
// Shared types for the hazard/tag pipeline: stage tag layout, bubble constant and stall FSM states.
package hazard_pkg;

  localparam int unsigned REG_W = 5;

  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             regwrite;
    logic             memread;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             valid;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '0;

  typedef enum logic [0:0] {
    RUN    = 1'b0,
    BUBBLE = 1'b1
  } stall_state_t;

endpackage

// File: rtl/hazard_tag_pipeline_if.sv
// ID-stage decode inputs and tag/stall outputs of hazard_tag_pipeline, grouped as one bundle.
interface hazard_tag_pipeline_if #(
  parameter int unsigned XLEN_REG = 5,
  parameter int unsigned STAT_W   = 16
);

  logic                VALID_ID;
  logic [XLEN_REG-1:0] ARD_ID;
  logic [XLEN_REG-1:0] ARS1_ID;
  logic [XLEN_REG-1:0] ARS2_ID;
  logic                USES_RS1_ID;
  logic                USES_RS2_ID;
  logic                REGWRITE_ID;
  logic                MEMREAD_ID;
  logic                FLUSH;
  logic                MEM_BUSY;

  logic                STALL;
  logic [XLEN_REG-1:0] ARS1;
  logic [XLEN_REG-1:0] ARS2;
  logic [XLEN_REG-1:0] ARD_EX_MEM;
  logic                REGWRITE_EX_MEM;
  logic [XLEN_REG-1:0] ARD_MEM_WB;
  logic                REGWRITE_MEM_WB;
  logic [STAT_W-1:0]   STALL_COUNT;

  modport master (
    output VALID_ID, ARD_ID, ARS1_ID, ARS2_ID, USES_RS1_ID, USES_RS2_ID,
    output REGWRITE_ID, MEMREAD_ID, FLUSH, MEM_BUSY,
    input  STALL, ARS1, ARS2, ARD_EX_MEM, REGWRITE_EX_MEM, ARD_MEM_WB, REGWRITE_MEM_WB,
    input  STALL_COUNT
  );

  modport slave (
    input  VALID_ID, ARD_ID, ARS1_ID, ARS2_ID, USES_RS1_ID, USES_RS2_ID,
    input  REGWRITE_ID, MEMREAD_ID, FLUSH, MEM_BUSY,
    output STALL, ARS1, ARS2, ARD_EX_MEM, REGWRITE_EX_MEM, ARD_MEM_WB, REGWRITE_MEM_WB,
    output STALL_COUNT
  );

endinterface

// File: rtl/hazard_tag_pipeline_stage_tag_reg.sv
// One pipeline tag register: hold has priority over bubble, bubble over normal load.
module stage_tag_reg
  import hazard_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       hold_i,
  input  logic       bubble_i,
  input  stage_tag_t d_i,
  output stage_tag_t q_o
);

  stage_tag_t tag_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tag_q <= BUBBLE_TAG;
    end else if (!hold_i) begin
      tag_q <= bubble_i ? BUBBLE_TAG : d_i;
    end
  end

  assign q_o = tag_q;

endmodule

// File: rtl/hazard_tag_pipeline.sv
// Tracks rd tags through ID/EX, EX/MEM, MEM/WB; load-use stall, branch flush, memory freeze.
// Optional saturating load-use stall counter: define HAZARD_STATS_EN.
module hazard_tag_pipeline
  import hazard_pkg::*;
#(
  parameter int unsigned XLEN_REG = 5,
  parameter int unsigned STAT_W   = 16
) (
  input logic                 CLK,
  input logic                 RST,
  hazard_tag_pipeline_if.slave bus
);

  localparam logic [XLEN_REG-1:0] RegZero = '0;

  stage_tag_t   id_tag;
  stage_tag_t   id_ex_q;
  stage_tag_t   ex_mem_q;
  stage_tag_t   mem_wb_q;
  stall_state_t state_q;

  logic hz_raw;
  logic hz;
  logic take_stall;

  // x0 writes and invalid slots never carry regwrite, so bubbles stay harmless downstream.
  always_comb begin
    id_tag          = BUBBLE_TAG;
    id_tag.valid    = bus.VALID_ID;
    id_tag.rd       = bus.ARD_ID;
    id_tag.rs1      = bus.ARS1_ID;
    id_tag.rs2      = bus.ARS2_ID;
    id_tag.regwrite = bus.REGWRITE_ID & bus.VALID_ID & (bus.ARD_ID != RegZero);
    id_tag.memread  = bus.MEMREAD_ID & bus.VALID_ID;
  end

  always_comb begin
    hz_raw = id_ex_q.valid & id_ex_q.memread & id_ex_q.regwrite & bus.VALID_ID &
             ((bus.USES_RS1_ID & (bus.ARS1_ID == id_ex_q.rd)) |
              (bus.USES_RS2_ID & (bus.ARS2_ID == id_ex_q.rd)));
    hz         = hz_raw & (state_q == RUN);
    take_stall = hz & ~bus.MEM_BUSY & ~bus.FLUSH;
  end

  // A flushed ID instruction is squashed, so it must not hold the front end.
  assign bus.STALL = ~RST & (bus.MEM_BUSY | take_stall);

  stage_tag_reg u_id_ex (
    .clk_i   (CLK),
    .rst_i   (RST),
    .hold_i  (bus.MEM_BUSY),
    .bubble_i(bus.FLUSH | hz),
    .d_i     (id_tag),
    .q_o     (id_ex_q)
  );

  stage_tag_reg u_ex_mem (
    .clk_i   (CLK),
    .rst_i   (RST),
    .hold_i  (bus.MEM_BUSY),
    .bubble_i(1'b0),
    .d_i     (id_ex_q),
    .q_o     (ex_mem_q)
  );

  stage_tag_reg u_mem_wb (
    .clk_i   (CLK),
    .rst_i   (RST),
    .hold_i  (bus.MEM_BUSY),
    .bubble_i(1'b0),
    .d_i     (ex_mem_q),
    .q_o     (mem_wb_q)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= RUN;
    end else if (!bus.MEM_BUSY) begin
      case (state_q)
        RUN:     if (take_stall) state_q <= BUBBLE;
        BUBBLE:  state_q <= RUN;
        default: state_q <= RUN;
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  logic [STAT_W-1:0] stall_cnt_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q <= '0;
    end else if (take_stall && (stall_cnt_q != {STAT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign bus.STALL_COUNT = stall_cnt_q;
`else
  assign bus.STALL_COUNT = {STAT_W{1'b0}};
`endif

  assign bus.ARS1            = id_ex_q.rs1;
  assign bus.ARS2            = id_ex_q.rs2;
  assign bus.ARD_EX_MEM      = ex_mem_q.rd;
  assign bus.REGWRITE_EX_MEM = ex_mem_q.regwrite;
  assign bus.ARD_MEM_WB      = mem_wb_q.rd;
  assign bus.REGWRITE_MEM_WB = mem_wb_q.regwrite;

  logic unused_tag_bits;
  assign unused_tag_bits = ^{ex_mem_q.memread, ex_mem_q.rs1, ex_mem_q.rs2, ex_mem_q.valid,
                             mem_wb_q.memread, mem_wb_q.rs1, mem_wb_q.rs2, mem_wb_q.valid};

  // The stall lasts one cycle because ID/EX always holds a bubble while in BUBBLE.
  a_bubble_no_hz: assert property (@(posedge CLK) disable iff (RST)
    (state_q == BUBBLE) |-> !hz_raw);

  a_no_x0_write: assert property (@(posedge CLK) disable iff (RST)
    !(id_ex_q.regwrite && (id_ex_q.rd == '0)));

endmodule
